// File: rtl/mesi_isc_fifo_pkg.sv
// mesi_isc_fifo_pkg: shared defaults, status struct and pointer-width helper for the MESI parametrised FIFO.
package mesi_isc_fifo_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_FIFO_SIZE = 4;
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_status_t;
  function automatic int ptr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mesi_isc_fifo_ptr.sv
// mesi_isc_fifo_ptr: wrap-around FIFO index counter, wraps at FIFO_SIZE-1 by compare so any depth works.
module mesi_isc_fifo_ptr
  import mesi_isc_fifo_pkg::*;
#(
  parameter int FIFO_SIZE = DEFAULT_FIFO_SIZE
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               inc,
  input  logic                               clr,
  output logic [ptr_width(FIFO_SIZE)-1:0]    ptr
);
  localparam int PW = ptr_width(FIFO_SIZE);
  localparam logic [PW-1:0] LAST = PW'(FIFO_SIZE - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
  end
endmodule

// File: rtl/mesi_isc_param_fifo.sv
// mesi_isc_param_fifo: any-depth FIFO with occupancy count, almost flags and flush.
// Define MESI_ISC_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module mesi_isc_param_fifo
  import mesi_isc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int FIFO_SIZE      = DEFAULT_FIFO_SIZE,
  parameter int FIFO_SIZE_LOG2 = $clog2(FIFO_SIZE),
  parameter int AF_MARGIN      = 1,
  parameter int AE_MARGIN      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    wr_i,
  input  logic                    rd_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    status_empty_o,
  output logic                    status_full_o,
  output logic                    status_almost_empty_o,
  output logic                    status_almost_full_o,
  output logic [FIFO_SIZE_LOG2:0] count_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);
  localparam int PW = ptr_width(FIFO_SIZE);
  localparam int CW = FIFO_SIZE_LOG2 + 1;
  localparam fifo_status_t ST_RST = '{
    empty: 1'b1,
    full: 1'b0,
    almost_empty: 1'b1,
    almost_full: (AF_MARGIN >= FIFO_SIZE)
  };
  logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
  logic [PW-1:0] ptr_wr, ptr_rd;
  logic [CW-1:0] count, count_nxt;
  fifo_status_t st, st_nxt;
  logic rd_acc, wr_acc;
  // A full FIFO still takes a write when a read frees the slot in the same cycle.
  assign rd_acc = rd_i && !flush_i && !st.empty;
  assign wr_acc = wr_i && !flush_i && (!st.full || rd_acc);
  always_comb begin
    count_nxt = flush_i ? '0 : count + CW'(wr_acc) - CW'(rd_acc);
    st_nxt.empty = (count_nxt == '0);
    st_nxt.full = (count_nxt == CW'(FIFO_SIZE));
    st_nxt.almost_empty = (int'(count_nxt) <= AE_MARGIN);
    st_nxt.almost_full = (int'(count_nxt) >= FIFO_SIZE - AF_MARGIN);
  end
  mesi_isc_fifo_ptr #(.FIFO_SIZE(FIFO_SIZE)) u_ptr_wr (
    .clk(clk), .rst(rst), .inc(wr_acc), .clr(flush_i), .ptr(ptr_wr)
  );
  mesi_isc_fifo_ptr #(.FIFO_SIZE(FIFO_SIZE)) u_ptr_rd (
    .clk(clk), .rst(rst), .inc(rd_acc), .clr(flush_i), .ptr(ptr_rd)
  );
  always_ff @(posedge clk) begin
    if (wr_acc) mem[ptr_wr] <= data_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      st <= ST_RST;
      data_o <= '0;
    end else begin
      count <= count_nxt;
      st <= st_nxt;
      if (rd_acc) data_o <= mem[ptr_rd];
    end
  end
  assign count_o = count;
  assign status_empty_o = st.empty;
  assign status_full_o = st.full;
  assign status_almost_empty_o = st.almost_empty;
  assign status_almost_full_o = st.almost_full;
`ifdef MESI_ISC_FIFO_ERR_EN
  // Sticky until reset; a flush is not an error and does not clear them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_o <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_i && !flush_i && !wr_acc) overflow_o <= 1'b1;
      if (rd_i && !flush_i && !rd_acc) underflow_o <= 1'b1;
    end
  end
`else
  assign overflow_o = 1'b0;
  assign underflow_o = 1'b0;
`endif
endmodule

// File: tb/tb_mesi_isc_param_fifo.sv
// tb_mesi_isc_param_fifo: directed scoreboard bench for a 5-deep, 32-bit mesi_isc_param_fifo.
module tb_mesi_isc_param_fifo;
  localparam int DW = 32;
  localparam int FS = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_i = 1'b0;
  logic wr_i = 1'b0;
  logic rd_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [DW-1:0] data_o;
  logic status_empty_o, status_full_o, status_almost_empty_o, status_almost_full_o;
  logic [3:0] count_o;
  logic overflow_o, underflow_o;
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_data = '0;
  logic exp_ovf = 1'b0;
  logic exp_unf = 1'b0;

  mesi_isc_param_fifo #(.DATA_WIDTH(DW), .FIFO_SIZE(FS), .AF_MARGIN(1), .AE_MARGIN(1)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .wr_i(wr_i), .rd_i(rd_i), .data_i(data_i),
    .data_o(data_o), .status_empty_o(status_empty_o), .status_full_o(status_full_o),
    .status_almost_empty_o(status_almost_empty_o), .status_almost_full_o(status_almost_full_o),
    .count_o(count_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ":data"}, data_o, exp_data);
    chk({tag, ":count"}, DW'(count_o), DW'(n));
    chk({tag, ":empty"}, DW'(status_empty_o), DW'(n == 0));
    chk({tag, ":full"}, DW'(status_full_o), DW'(n == FS));
    chk({tag, ":aempty"}, DW'(status_almost_empty_o), DW'(n <= 1));
    chk({tag, ":afull"}, DW'(status_almost_full_o), DW'(n >= FS - 1));
    chk({tag, ":ovf"}, DW'(overflow_o), DW'(exp_ovf));
    chk({tag, ":unf"}, DW'(underflow_o), DW'(exp_unf));
  endtask

  task automatic step(input logic wr, input logic rd, input logic fl, input logic [DW-1:0] d,
                      input string tag);
    logic ra, wa;
    @(negedge clk);
    wr_i = wr;
    rd_i = rd;
    flush_i = fl;
    data_i = d;
    @(posedge clk);
    ra = rd && !fl && (q.size() > 0);
    wa = wr && !fl && (q.size() < FS || ra);
    if (ra) exp_data = q.pop_front();
    if (wa) q.push_back(d);
    if (fl) q.delete();
`ifdef MESI_ISC_FIFO_ERR_EN
    if (wr && !fl && !wa) exp_ovf = 1'b1;
    if (rd && !fl && !ra) exp_unf = 1'b1;
`endif
    #1;
    wr_i = 1'b0;
    rd_i = 1'b0;
    flush_i = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b0, DW'(i * 'h11), "fill");
    step(1'b1, 1'b0, 1'b0, 32'h99, "wr_full");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, '0, "drain");
    chk("drain_last", data_o, 32'h55);
    step(1'b0, 1'b1, 1'b0, '0, "rd_empty");
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b0, DW'(i * 'h11), "refill");
    step(1'b1, 1'b1, 1'b0, 32'h66, "rdwr_full");
    chk("rdwr_full_head", data_o, 32'h11);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, '0, "wrap_rd");
    chk("wrap_last", data_o, 32'h66);
    step(1'b1, 1'b1, 1'b0, 32'hAA, "rdwr_empty");
    step(1'b0, 1'b1, 1'b0, '0, "rd_aa");
    chk("rd_aa_val", data_o, 32'hAA);
    step(1'b1, 1'b0, 1'b0, 32'hB1, "one");
    step(1'b1, 1'b1, 1'b0, 32'hB2, "rdwr_one");
    step(1'b0, 1'b1, 1'b0, '0, "rd_b2");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, DW'(32'hC0 + i), "pre_flush");
    step(1'b1, 1'b0, 1'b1, 32'hEE, "flush");
    chk("flush_data", data_o, 32'hB2);
    step(1'b0, 1'b1, 1'b0, '0, "post_flush_rd");
    step(1'b1, 1'b0, 1'b0, 32'hD1, "pre_rst");
    step(1'b1, 1'b0, 1'b0, 32'hD2, "pre_rst");
    #3;
    rst = 1'b1;
    #1;
    q.delete();
    exp_data = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    chk_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'h77, "after_rst");
    step(1'b0, 1'b1, 1'b0, '0, "after_rst_rd");
    chk("after_rst_val", data_o, 32'h77);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mesi_isc_param_fifo.md
# mesi_isc_param_fifo

Parametrised successor to the basic 4-entry FIFO used throughout the MESI interconnect (broadcast and bus-request queues). Supports any depth ≥ 2, including non-power-of-two, and exposes an unambiguous occupancy count, programmable almost-full/almost-empty flags and a synchronous flush. Illegal operations are dropped safely rather than being left undefined. It is a drop-in replacement wherever `mesi_isc_basic_fifo` is instantiated; only the new ports need tying off.

## Interface
- `DATA_WIDTH`, 32, entry width in bits
- `FIFO_SIZE`, 4, number of entries; any value ≥ 2
- `FIFO_SIZE_LOG2`, $clog2(FIFO_SIZE), pointer width; derived, not overridden
- `AF_MARGIN`, 1, almost-full asserts when count ≥ FIFO_SIZE−AF_MARGIN
- `AE_MARGIN`, 1, almost-empty asserts when count ≤ AE_MARGIN
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `flush_i`  in  1  synchronous clear of contents
- `wr_i`  in  1  write request
- `rd_i`  in  1  read request
- `data_i`  in  DATA_WIDTH  write data
- `data_o`  out  DATA_WIDTH  registered read data
- `status_empty_o`  out  1  count == 0
- `status_full_o`  out  1  count == FIFO_SIZE
- `status_almost_empty_o`  out  1  count ≤ AE_MARGIN
- `status_almost_full_o`  out  1  count ≥ FIFO_SIZE−AF_MARGIN
- `count_o`  out  FIFO_SIZE_LOG2+1  occupancy, 0..FIFO_SIZE
- `overflow_o`  out  1  sticky: write dropped while full
- `underflow_o`  out  1  sticky: read dropped while empty

## Operation
- Reset values: `ptr_wr` = `ptr_rd` = 0, `count_o` = 0, `data_o` = 0, `status_empty_o` = 1, `status_almost_empty_o` = 1, `status_full_o` = 0, `status_almost_full_o` = 0 (1 if AF_MARGIN ≥ FIFO_SIZE), `overflow_o` = `underflow_o` = 0. Entry array is not reset.
- Write acceptance: wr_acc = `wr_i` && (!full || rd_acc). Entry[ptr_wr] ← `data_i`.
- Read acceptance: rd_acc = `rd_i` && !empty. `data_o` ← entry[ptr_rd].
- Read while empty is dropped, even with a simultaneous write. No bypass: the written word appears on a later read.
- Write while full with an accepted read is accepted; count is unchanged.
- Write while full without a read is dropped, and the entry array is untouched.
- Pointers wrap from FIFO_SIZE−1 to 0 by explicit compare, not by modulo-2^n.
- Count update: count ← count + wr_acc − rd_acc. The count is held in FIFO_SIZE_LOG2+1 bits, so full and empty never alias.
- Flush: `flush_i` = 1 clears pointers and count and forces flags to their reset values. It overrides `wr_i`/`rd_i` in the same cycle. `data_o` and the sticky error flags hold their values.
- All status flags are registered and computed from the next-state count, so they are valid in the cycle after the operation.

## Timing
- Read latency is 1 cycle: `rd_i` sampled at edge N puts the head word on `data_o` after edge N. `data_o` holds until the next accepted read.
- Write-to-readable latency is 1 cycle: `status_empty_o` deasserts after the edge that accepted the first write.
- Simultaneous rd+wr with count = 1: `data_o` ← old head, the new word becomes head, and `status_empty_o` stays 0.
- Reset asserted mid-operation: all registers go to reset values immediately (asynchronous). The first write is accepted on the first rising edge with `rst` low.

## Configuration
- `MESI_ISC_FIFO_ERR_EN` defined: `overflow_o` sets on a dropped write and `underflow_o` sets on a dropped read. Both are sticky until `rst`.
- `MESI_ISC_FIFO_ERR_EN` undefined: both outputs are tied to 0 and no error logic is synthesised. Drop behaviour is identical in both builds.

## Structure
- Package `mesi_isc_fifo_pkg` holds:
  - the `count_t`/`ptr_t` width helper function (clog2 with minimum 1);
  - a `fifo_status_t` packed struct {empty, full, almost_empty, almost_full};
  - the default `DATA_WIDTH`/`FIFO_SIZE` constants.
- Sub-module `mesi_isc_fifo_ptr` is a wrap-around pointer counter (parameter FIFO_SIZE; inputs inc, clr; output ptr). It is instantiated twice, once for write and once for read.

## Test plan
1. DATA_WIDTH=32, FIFO_SIZE=5. Write 0x11..0x55 → `status_full_o`=1, `count_o`=5, `status_almost_full_o` set after the 4th write. A 6th write is dropped and `overflow_o`=1 (ERR_EN).
2. Same configuration, full FIFO. Read 5 times → `data_o` = 0x11,0x22,0x33,0x44,0x55 in order, `status_empty_o`=1 after the 5th. A 6th read leaves `data_o`=0x55 and sets `underflow_o`=1.
3. Full FIFO, simultaneous rd+wr of 0x66 → `data_o`=0x11, `count_o` stays 5. Five further reads return 0x22..0x55, then 0x66, proving wrap at index 4→0.
4. Empty FIFO, rd+wr 0xAA in the same cycle → read dropped, `count_o`=1. The next read returns 0xAA.
5. count=3, assert `flush_i` with `wr_i`=1 → `count_o`=0, `status_empty_o`=1, the write is ignored, and `data_o` is unchanged.
6. Assert `rst` asynchronously between edges while count=2 → all outputs take their reset values before the next edge.
